instr_encoder_loader: RTL and testbench

- Encoder counterpart of the single-cycle core's instruction decoder.
- Accepts field-level instruction descriptions over a valid/ready handshake and packs them into RV32I 32-bit words (R/I/S/B/U/J formats).
- Writes the words sequentially into instruction memory through a simple write port.
- Used to load programs and to generate decoder/core test stimulus in-system without external memory-init files.

---
 rtl/instr_enc_pkg.sv | 51 +++++
 rtl/instr_encoder_loader_if.sv | 26 ++
 rtl/rv32_field_packer.sv | 45 ++++
 rtl/instr_encoder_loader.sv | 105 ++++++++++
 tb/tb_instr_encoder_loader.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I field-to-word encoder/loader.
package instr_enc_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned FMT_W = 3;
   localparam int unsigned OPC_W = 7;
   localparam int unsigned F3_W  = 3;
   localparam int unsigned F7_W  = 7;
   localparam int unsigned REG_W = 5;

   typedef enum logic [FMT_W-1:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

   typedef struct packed {
      logic [FMT_W-1:0] fmt;
      logic [OPC_W-1:0] opcode;
      logic [F3_W-1:0]  funct3;
      logic [F7_W-1:0]  funct7;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [XLEN-1:0]  imm;
   } instr_fields_t;

   // True when value survives truncation to a signed field of the given width.
   function automatic logic fits_signed(input logic [XLEN-1:0] value, input int unsigned bits);
      logic [XLEN-1:0] ext;
      ext = XLEN'($signed(value) >>> (bits - 1));
      return (ext == '0) || (ext == '1);
   endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake between a program source and the encoder.
interface instr_encoder_loader_if;
   import instr_enc_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [FMT_W-1:0]     fmt;
   logic [OPC_W-1:0]     opcode;
   logic [F3_W-1:0]      funct3;
   logic [F7_W-1:0]      funct7;
   logic [REG_W-1:0]     rd;
   logic [REG_W-1:0]     rs1;
   logic [REG_W-1:0]     rs2;
   logic [XLEN-1:0]      imm;

   modport master (
      output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
      input  in_ready
   );

   modport slave (
      input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
      output in_ready
   );

endinterface

// File: rtl/rv32_field_packer.sv
// Combinational RV32I packer: field bundle to 32-bit word plus a legality flag.
module rv32_field_packer
   import instr_enc_pkg::*;
(
   input  instr_fields_t     fields,
   output logic [XLEN-1:0]   word,
   output logic              legal
);

   logic fmt_ok;
   logic imm_ok;

   always_comb begin
      word   = '0;
      fmt_ok = 1'b1;
      imm_ok = 1'b1;
      case (fields.fmt)
         FMT_R: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                        fields.rd, fields.opcode};
         FMT_I: begin
            word   = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
            imm_ok = fits_signed(fields.imm, 12);
         end
         FMT_S: begin
            word   = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                      fields.imm[4:0], fields.opcode};
            imm_ok = fits_signed(fields.imm, 12);
         end
         FMT_B: begin
            word   = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                      fields.imm[4:1], fields.imm[11], fields.opcode};
            imm_ok = fits_signed(fields.imm, 13) && !fields.imm[0];
         end
         FMT_U: word = {fields.imm[31:12], fields.rd, fields.opcode};
         FMT_J: begin
            word   = {fields.imm[20], fields.imm[10:1], fields.imm[11], fields.imm[19:12],
                      fields.rd, fields.opcode};
            imm_ok = fits_signed(fields.imm, 21) && !fields.imm[0];
         end
         default: fmt_ok = 1'b0;
      endcase
      legal = fmt_ok && imm_ok && (fields.opcode[1:0] == 2'b11);
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts field bundles, packs them into RV32I words and writes them sequentially
// into instruction memory; one-cycle latency, one word per cycle.
module instr_encoder_loader
   import instr_enc_pkg::*;
#(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DEPTH  = 128
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 finish,
   instr_encoder_loader_if.slave bus,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [XLEN-1:0]      mem_wdata,
   output logic [ADDR_W:0]      count,
   output logic                 full,
   output logic                 err,
   output logic                 busy
);

   localparam int unsigned      CNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   state_e           state_q;
   state_e           state_d;
   instr_fields_t    fields;
   logic [XLEN-1:0]  packed_word;
   logic             packed_legal;
   logic [CNT_W-1:0] count_d;
   logic             room;
   logic             accept;
   logic             last_write;

   assign fields = '{fmt:    bus.fmt,
                     opcode: bus.opcode,
                     funct3: bus.funct3,
                     funct7: bus.funct7,
                     rd:     bus.rd,
                     rs1:    bus.rs1,
                     rs2:    bus.rs2,
                     imm:    bus.imm};

   rv32_field_packer u_packer (
      .fields (fields),
      .word   (packed_word),
      .legal  (packed_legal)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state: start always (re)enters LOAD; LOAD ends on finish or the last write
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_LOAD;
      end else if ((state_q == ST_LOAD) && (finish || last_write)) begin
         state_d = ST_DONE;
      end
   end

   // Handshake and counter next values; an in-flight write already owns a slot
   always_comb begin
      count_d      = start ? '0 : count + CNT_W'(mem_we);
      room         = (count + CNT_W'(mem_we)) < DEPTH_CNT;
      bus.in_ready = (state_q == ST_LOAD) && room && !full && !finish && !start;
      accept       = bus.in_valid && bus.in_ready;
      last_write   = mem_we && ((count + CNT_W'(1)) == DEPTH_CNT);
   end

   // Write port and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         count     <= '0;
         full      <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         count  <= count_d;
         full   <= (count_d == DEPTH_CNT);
         busy   <= (state_d == ST_LOAD);
         if (start) begin
            err <= 1'b0;
         end else if (accept) begin
            if (packed_legal) begin
               mem_we    <= 1'b1;
               mem_addr  <= count_d[ADDR_W-1:0];
               mem_wdata <= packed_word;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomised and directed check of instr_encoder_loader against a cycle-level model.
module tb_instr_encoder_loader;
   import instr_enc_pkg::*;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DEPTH  = 4;
   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_DONE = 2;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic start  = 1'b0;
   logic finish = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;
   logic              busy;

   instr_encoder_loader_if bus ();

   instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .finish    (finish),
      .bus       (bus),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .count     (count),
      .full      (full),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks  = 0;
   int errors  = 0;
   int wr_seen = 0;

   // Reference state: phase, words written, sticky error, write on the port now
   int          m_state;
   int          m_cnt;
   bit          m_err;
   bit          m_we;
   int          m_addr;
   logic [31:0] m_wdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void ref_encode(input logic [2:0] f, input logic [6:0] op,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm,
                                      output logic [31:0] w, output bit ok);
      int s;
      s  = int'($signed(imm));
      ok = (op[1:0] == 2'b11);
      w  = 32'h0;
      case (f)
         3'd0: w = {f7, rs2, rs1, f3, rd, op};
         3'd1: begin
            ok = ok && (s >= -2048) && (s <= 2047);
            w  = {imm[11:0], rs1, f3, rd, op};
         end
         3'd2: begin
            ok = ok && (s >= -2048) && (s <= 2047);
            w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         end
         3'd3: begin
            ok = ok && (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         end
         3'd4: w = {imm[31:12], rd, op};
         3'd5: begin
            ok = ok && (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
            w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         end
         default: ok = 1'b0;
      endcase
   endfunction

   function automatic bit ready_model();
      return (m_state == M_LOAD) && !start && !finish && ((m_cnt + int'(m_we)) < int'(DEPTH));
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_cnt   = 0;
      m_err   = 1'b0;
      m_we    = 1'b0;
      m_addr  = 0;
      m_wdata = 32'h0;
   endtask

   task automatic model_edge(input bit acc);
      logic [31:0] w;
      bit          ok;
      if (start) begin
         m_state = M_LOAD;
         m_cnt   = 0;
         m_err   = 1'b0;
         m_we    = 1'b0;
      end else begin
         if (m_we) m_cnt++;
         if ((m_state == M_LOAD) && (finish || (m_we && m_cnt == int'(DEPTH)))) m_state = M_DONE;
         m_we = 1'b0;
         if (acc) begin
            ref_encode(bus.fmt, bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1,
                       bus.rs2, bus.imm, w, ok);
            if (ok) begin
               m_we    = 1'b1;
               m_addr  = m_cnt;
               m_wdata = w;
            end else begin
               m_err = 1'b1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      check("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) check("mem_addr", 32'(mem_addr), 32'(m_addr));
      check("mem_wdata", mem_wdata, m_wdata);
      check("count", 32'(count), 32'(m_cnt));
      check("full", 32'(full), 32'(m_cnt == int'(DEPTH)));
      check("err", 32'(err), 32'(m_err));
      check("busy", 32'(busy), 32'(m_state == M_LOAD));
      if (mem_we === 1'b1) wr_seen++;
   endtask

   // One clock: inputs already applied after the falling edge
   task automatic tick();
      bit acc;
      #1;
      acc = ready_model() && bus.in_valid;
      check("in_ready", 32'(bus.in_ready), 32'(ready_model()));
      @(posedge clk);
      model_edge(acc);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_bundle(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm);
      bus.in_valid = 1'b1;
      bus.fmt      = f;
      bus.opcode   = op;
      bus.funct3   = f3;
      bus.funct7   = f7;
      bus.rd       = rd;
      bus.rs1      = rs1;
      bus.rs2      = rs2;
      bus.imm      = imm;
   endtask

   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
      set_bundle(f, op, f3, f7, rd, rs1, rs2, imm);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      bus.in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic rand_bundle();
      logic [2:0]  f;
      logic [6:0]  op;
      logic [31:0] imm;
      int          v;
      int          edges [11];
      edges = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, -4098, 1048574, -1048576, 1048576};
      f = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      case (f)
         3'd0:    op = OP_REG;
         3'd1:    op = OP_IMM;
         3'd2:    op = OP_STORE;
         3'd3:    op = OP_BRANCH;
         3'd4:    op = OP_LUI;
         default: op = OP_JAL;
      endcase
      if ($urandom_range(0, 15) == 0) op = 7'($urandom());
      case ($urandom_range(0, 2))
         0: begin
            v   = int'($urandom_range(0, 80)) - 40;
            imm = 32'(v);
         end
         1:       imm = 32'(edges[$urandom_range(0, 10)]);
         default: imm = $urandom();
      endcase
      if ((f == 3'd3 || f == 3'd5) && $urandom_range(0, 3) != 0) imm[0] = 1'b0;
      set_bundle(f, op, 3'($urandom()), 7'($urandom()), 5'($urandom()), 5'($urandom()),
                 5'($urandom()), imm);
   endtask

   initial begin
      set_bundle(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      bus.in_valid = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs();
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      rst_n = 1'b1;

      // R-type
      pulse_start();
      send(3'd0, OP_REG, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
      check("r_word", mem_wdata, 32'h002081B3);
      check("r_addr", 32'(mem_addr), 32'd0);
      idle_cycles(1);
      check("r_count", 32'(count), 32'd1);

      // I and S back-to-back
      pulse_start();
      send(3'd1, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      check("i_word", mem_wdata, 32'h00500093);
      send(3'd2, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
      check("s_word", mem_wdata, 32'h0020A423);
      check("s_addr", 32'(mem_addr), 32'd1);
      check("s_we_b2b", 32'(mem_we), 32'd1);
      idle_cycles(1);
      check("is_count", 32'(count), 32'd2);

      // B/J packing and a misaligned branch
      pulse_start();
      send(3'd3, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
      check("b_word", mem_wdata, 32'hFE208EE3);
      send(3'd5, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
      check("j_word", mem_wdata, 32'h008000EF);
      send(3'd3, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
      check("b_odd_we", 32'(mem_we), 32'd0);
      check("b_odd_err", 32'(err), 32'd1);
      idle_cycles(1);
      check("b_odd_count", 32'(count), 32'd2);

      // Fill to DEPTH with six offered bundles
      pulse_start();
      wr_seen = 0;
      for (int i = 0; i < 6; i++) send(3'd1, OP_IMM, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
      idle_cycles(2);
      check("full_writes", 32'(wr_seen), 32'(DEPTH));
      check("full_flag", 32'(full), 32'd1);
      check("full_busy", 32'(busy), 32'd0);
      bus.in_valid = 1'b1;
      #1 check("full_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      pulse_start();
      check("restart_count", 32'(count), 32'd0);
      check("restart_full", 32'(full), 32'd0);
      #1 check("restart_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      check_outputs();

      // finish together with in_valid
      set_bundle(3'd1, OP_IMM, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd1);
      finish = 1'b1;
      tick();
      finish = 1'b0;
      bus.in_valid = 1'b0;
      check("fin_busy", 32'(busy), 32'd0);
      idle_cycles(1);
      check("fin_no_we", 32'(mem_we), 32'd0);

      // start while a write is on the port
      pulse_start();
      send(3'd6, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
      send(3'd1, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
      set_bundle(3'd1, OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd9);
      start = 1'b1;
      tick();
      start = 1'b0;
      bus.in_valid = 1'b0;
      check("st_count", 32'(count), 32'd0);
      check("st_err", 32'(err), 32'd0);
      check("st_we", 32'(mem_we), 32'd0);

      // Asynchronous reset mid-stream
      send(3'd4, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
      set_bundle(3'd1, OP_IMM, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'd3);
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
      check("mid_rst_addr", 32'(mem_addr), 32'd0);
      #1 rst_n = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      idle_cycles(1);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         start  = ($urandom_range(0, 24) == 0);
         finish = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 9) < 7) rand_bundle();
         else bus.in_valid = 1'b0;
         tick();
      end
      start  = 1'b0;
      finish = 1'b0;
      idle_cycles(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
